// File: rtl/video_pkg.sv
// Shared types and constants for the video frame reader.
// Avalon-MM widths, FSM state encoding and burst sizing helper.
package video_pkg;

    localparam int AV_DATA_W  = 32;
    localparam int AV_ADDR_W  = 32;
    localparam int AV_BURST_W = 9;
    localparam int WL_W       = 20;
    localparam int OUT_W      = 10;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        REQ,
        DRAIN,
        FLUSH
    } state_t;

    // Size of the next burst: the full burst length or whatever is left.
    function automatic logic [AV_BURST_W-1:0] min_blen(
        input logic [WL_W-1:0]       left,
        input logic [AV_BURST_W-1:0] max_len
    );
        if (left < WL_W'(max_len)) begin
            return left[AV_BURST_W-1:0];
        end
        return max_len;
    endfunction

endpackage

// File: rtl/video_pix_fifo.sv
// Synchronous first-word-fall-through FIFO for pixel words.
// Ports: clk, reset_n (sync, active low), flush, push/din, pop, dout, empty, count.
module video_pix_fifo
    import video_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int DW    = AV_DATA_W,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_pop;

    assign empty  = (cnt_q == '0);
    assign do_pop = pop && !empty;
    // Head word is driven as zero while empty so the output is clean.
    assign dout   = empty ? '0 : mem_q[rd_q];
    assign count  = cnt_q;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) begin
            wr_d = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        case ({push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_q] <= din;
        end
    end

endmodule

// File: rtl/video_frame_reader.sv
// Avalon-MM burst read master fetching a 32bpp frame into a pixel stream.
// Ports: Avalon master m_*, frame control, pix_* stream, busy/overrun/underrun.
module video_frame_reader
    import video_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int BURST_LEN  = 64,
    parameter int FIFO_DEPTH = 512
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [AV_ADDR_W-1:0]  frame_base,
    input  logic                  frame_start,
    output logic [AV_ADDR_W-1:0]  m_address,
    output logic [AV_BURST_W-1:0] m_burstcount,
    output logic                  m_read,
    output logic                  m_write,
    output logic [AV_DATA_W-1:0]  m_writedata,
    output logic [3:0]            m_byteenable,
    output logic                  m_debugaccess,
    input  logic                  m_waitrequest,
    input  logic [AV_DATA_W-1:0]  m_readdata,
    input  logic                  m_readdatavalid,
    output logic [AV_DATA_W-1:0]  pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  busy,
    output logic                  overrun,
    output logic                  underrun
);

    localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [WL_W-1:0] FRAME_WORDS = WL_W'(H_ACTIVE * V_ACTIVE);

    state_t                state_q, state_d;
    logic [AV_ADDR_W-1:0]  addr_q, addr_d;
    logic [WL_W-1:0]       left_q, left_d;
    logic [OUT_W-1:0]      outstanding_q, outstanding_d;
    logic                  wait_q, wait_d;
    logic                  overrun_q, overrun_d;
    logic                  underrun_q, underrun_d;

    logic [AV_BURST_W-1:0] blen;
    logic [FIFO_CW-1:0]    fifo_count;
    logic                  fifo_empty;
    logic                  credit_ok;
    logic                  accept;
    logic                  in_frame;
    logic                  push;
    logic                  ret;
    logic                  pop;
    logic                  flush;

    assign blen      = min_blen(left_q, AV_BURST_W'(BURST_LEN));
    // Words already buffered plus words in flight plus this burst must fit.
    assign credit_ok = (32'(fifo_count) + 32'(outstanding_q) + 32'(blen))
                       <= 32'(FIFO_DEPTH);
    // A read stalled by waitrequest stays up even if enable drops.
    assign m_read    = (state_q == REQ)
                     && (wait_q || (enable && credit_ok && blen != '0));
    assign accept    = m_read && !m_waitrequest;
    assign in_frame  = (state_q == REQ) || (state_q == DRAIN);
    assign push      = m_readdatavalid && in_frame;
    assign ret       = m_readdatavalid && (in_frame || state_q == FLUSH)
                     && (outstanding_q != '0);
    assign pop       = !fifo_empty && pix_ready;

    assign m_address     = m_read ? addr_q : '0;
    assign m_burstcount  = m_read ? blen : '0;
    assign m_write       = 1'b0;
    assign m_writedata   = '0;
    assign m_byteenable  = 4'hF;
    assign m_debugaccess = 1'b0;

    assign pix_valid = !fifo_empty;
    assign busy      = !((state_q == IDLE) || (state_q == ARMED));
    assign overrun   = overrun_q;
    assign underrun  = underrun_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        left_d        = left_q;
        wait_d        = m_read && m_waitrequest;
        overrun_d     = overrun_q;
        underrun_d    = underrun_q;
        flush         = 1'b0;
        outstanding_d = outstanding_q
                      + (accept ? OUT_W'(blen) : '0)
                      - (ret ? OUT_W'(1) : '0);

        if (accept) begin
            addr_d = addr_q + AV_ADDR_W'({blen, 2'b00});
            left_d = left_q - WL_W'(blen);
        end
        if (in_frame && frame_start) begin
            overrun_d = 1'b1;
        end
        if (in_frame && pix_ready && fifo_empty) begin
            underrun_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!enable) begin
                    state_d = FLUSH;
                end else if (frame_start) begin
                    addr_d  = frame_base;
                    left_d  = FRAME_WORDS;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!enable && !wait_d) begin
                    state_d = FLUSH;
                end else if (accept && left_d == '0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!enable) begin
                    state_d = FLUSH;
                end else if (outstanding_q == '0) begin
                    state_d = ARMED;
                end
            end
            FLUSH: begin
                if (outstanding_q == '0) begin
                    flush      = 1'b1;
                    overrun_d  = 1'b0;
                    underrun_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            left_q        <= '0;
            outstanding_q <= '0;
            wait_q        <= 1'b0;
            overrun_q     <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            left_q        <= left_d;
            outstanding_q <= outstanding_d;
            wait_q        <= wait_d;
            overrun_q     <= overrun_d;
            underrun_q    <= underrun_d;
        end
    end

    video_pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (AV_DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (push),
        .din     (m_readdata),
        .pop     (pop),
        .dout    (pix_data),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_video_frame_reader.sv
// Directed bench for video_frame_reader with a 3-cycle latency slave.
// Two instances (8x2 and 5x2) share one slave model, selected by sel.
module tb_video_frame_reader;
    import video_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    logic        en_a = 1'b0, en_b = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_ready = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] frame_base = '0;
    logic        s_wait;
    logic        s_rdv = 1'b0;
    logic [31:0] s_rdata = '0;

    logic [31:0] a_addr, a_wdata, a_pdata, b_addr, b_wdata, b_pdata;
    logic [8:0]  a_bc, b_bc;
    logic [3:0]  a_be, b_be;
    logic a_read, a_write, a_dbg, a_pvalid, a_busy, a_ovr, a_udr;
    logic b_read, b_write, b_dbg, b_pvalid, b_busy, b_ovr, b_udr;

    video_frame_reader #(.H_ACTIVE(8), .V_ACTIVE(2), .BURST_LEN(4),
                         .FIFO_DEPTH(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .enable(en_a),
        .frame_base(frame_base), .frame_start(frame_start),
        .m_address(a_addr), .m_burstcount(a_bc), .m_read(a_read),
        .m_write(a_write), .m_writedata(a_wdata), .m_byteenable(a_be),
        .m_debugaccess(a_dbg), .m_waitrequest(s_wait),
        .m_readdata(s_rdata), .m_readdatavalid(s_rdv),
        .pix_data(a_pdata), .pix_valid(a_pvalid), .pix_ready(pix_ready),
        .busy(a_busy), .overrun(a_ovr), .underrun(a_udr)
    );

    video_frame_reader #(.H_ACTIVE(5), .V_ACTIVE(2), .BURST_LEN(4),
                         .FIFO_DEPTH(16)) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(en_b),
        .frame_base(frame_base), .frame_start(frame_start),
        .m_address(b_addr), .m_burstcount(b_bc), .m_read(b_read),
        .m_write(b_write), .m_writedata(b_wdata), .m_byteenable(b_be),
        .m_debugaccess(b_dbg), .m_waitrequest(s_wait),
        .m_readdata(s_rdata), .m_readdatavalid(s_rdv),
        .pix_data(b_pdata), .pix_valid(b_pvalid), .pix_ready(pix_ready),
        .busy(b_busy), .overrun(b_ovr), .underrun(b_udr)
    );

    logic        s_read, s_pvalid, s_busy;
    logic [31:0] s_addr, s_pdata;
    logic [8:0]  s_bc;
    assign s_read   = sel ? b_read : a_read;
    assign s_addr   = sel ? b_addr : a_addr;
    assign s_bc     = sel ? b_bc : a_bc;
    assign s_pvalid = sel ? b_pvalid : a_pvalid;
    assign s_pdata  = sel ? b_pdata : a_pdata;
    assign s_busy   = sel ? b_busy : a_busy;

    int checks = 0, errors = 0;
    int n_acc = 0, wait_on = -1, wait_seen = 0, wait_lim = 0;
    int stab_viol = 0, cyc = 0, last_due = -1, max_cred = 0, cred;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [8:0]  prev_bc = '0;
    logic [31:0] acc_addr[$], q_addr[$], pix_q[$];
    int          acc_cnt[$], q_due[$];

    assign s_wait = s_read && (n_acc == wait_on) && (wait_seen < wait_lim);

    // Slave model: beats of an accepted burst start 3 cycles later, data = address.
    always @(posedge clk) begin
        int d;
        if (s_read && s_wait) wait_seen <= wait_seen + 1;
        if (prev_hold && (!s_read || s_addr != prev_addr || s_bc != prev_bc))
            stab_viol++;
        prev_hold = s_read && s_wait;
        prev_addr = s_addr;
        prev_bc   = s_bc;
        if (s_read && !s_wait) begin
            acc_addr.push_back(s_addr);
            acc_cnt.push_back(int'(s_bc));
            n_acc <= n_acc + 1;
            d = (cyc + 3 > last_due) ? cyc + 3 : last_due + 1;
            for (int i = 0; i < int'(s_bc); i++) begin
                q_addr.push_back(s_addr + 32'(4 * i));
                q_due.push_back(d + i);
            end
            last_due = d + int'(s_bc) - 1;
        end
        if (q_due.size() > 0 && q_due[0] <= cyc) begin
            s_rdv   <= 1'b1;
            s_rdata <= q_addr.pop_front();
            void'(q_due.pop_front());
        end else begin
            s_rdv   <= 1'b0;
            s_rdata <= '0;
        end
        if (s_pvalid && pix_ready) pix_q.push_back(s_pdata);
        cred = int'(dut_a.fifo_count) + int'(dut_a.outstanding_q);
        if (cred > max_cred) max_cred = cred;
        cyc++;
    end

    always @(posedge clk) begin
        assert (int'(dut_a.fifo_count) <= 16 && int'(dut_b.fifo_count) <= 16)
        else begin
            errors++;
            $error("FAIL fifo_overflow: a=%0d b=%0d limit 16",
                   dut_a.fifo_count, dut_b.fifo_count);
        end
    end

    task automatic clear_logs();
        acc_addr.delete();
        acc_cnt.delete();
        pix_q.delete();
    endtask

    task automatic pulse_start(input logic [31:0] base);
        frame_base  = base;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int npix, input string name);
        int t = 0;
        while (!(pix_q.size() >= npix && !s_busy && q_due.size() == 0)
               && t < 2000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 2000) begin
            errors++;
            $display("FAIL %s_timeout: pixels=%0d busy=%0b want %0d idle",
                     name, pix_q.size(), s_busy, npix);
        end
    endtask

    task automatic wait_first_burst(input string name);
        int t = 0;
        while (acc_addr.size() < 1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 50) begin
            errors++;
            $display("FAIL %s_first_burst: none accepted in 50 cycles", name);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_read, a_write, a_dbg} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 000", {a_read, a_write, a_dbg});
        end
        checks++;
        if (a_addr !== 32'h0 || a_bc !== 9'h0 || a_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h bc=%0d wd=%h want 0",
                     a_addr, a_bc, a_wdata);
        end
        checks++;
        if (a_be !== 4'hF) begin
            errors++;
            $display("FAIL reset_be: got %h want f", a_be);
        end
        checks++;
        if ({a_pvalid, a_busy, a_ovr, a_udr} !== 4'b0 || a_pdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_stat: flags=%b pix=%h want 0",
                     {a_pvalid, a_busy, a_ovr, a_udr}, a_pdata);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        int bad = 0;
        sel = 1'b0;
        en_a = 1'b1;
        pix_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (dut_a.state_q !== ARMED) begin
            errors++;
            $display("FAIL basic_armed: state=%0d want ARMED", dut_a.state_q);
        end
        clear_logs();
        pulse_start(32'h3000_0000);
        wait_done(16, "basic");
        for (int i = 0; i < acc_addr.size(); i++)
            if (acc_addr[i] !== 32'h3000_0000 + 32'(16 * i) || acc_cnt[i] != 4)
                bad++;
        checks++;
        if (acc_addr.size() != 4 || bad != 0) begin
            errors++;
            $display("FAIL basic_bursts: n=%0d bad=%0d want 4 bursts of 4 @+0x10",
                     acc_addr.size(), bad);
        end
        bad = 0;
        for (int i = 0; i < pix_q.size(); i++)
            if (pix_q[i] !== 32'h3000_0000 + 32'(4 * i)) bad++;
        checks++;
        if (pix_q.size() != 16 || bad != 0) begin
            errors++;
            $display("FAIL basic_pixels: n=%0d bad=%0d want 16 in order",
                     pix_q.size(), bad);
        end
        checks++;
        if (dut_a.state_q !== ARMED || a_ovr !== 1'b0) begin
            errors++;
            $display("FAIL basic_end: state=%0d ovr=%b want ARMED 0",
                     dut_a.state_q, a_ovr);
        end
    endtask

    task automatic test_truncated();
        int bad = 0;
        int exp_bc[3] = '{4, 4, 2};
        logic [31:0] base = 32'hFFFF_FFF0;
        en_a = 1'b0;
        repeat (4) @(negedge clk);
        sel  = 1'b1;
        en_b = 1'b1;
        repeat (2) @(negedge clk);
        clear_logs();
        pulse_start(base);
        wait_done(10, "trunc");
        for (int i = 0; i < acc_addr.size() && i < 3; i++)
            if (acc_addr[i] !== base + 32'(16 * i) || acc_cnt[i] != exp_bc[i])
                bad++;
        checks++;
        if (acc_addr.size() != 3 || bad != 0) begin
            errors++;
            $display("FAIL trunc_bursts: n=%0d bad=%0d want 4,4,2 wrapping",
                     acc_addr.size(), bad);
        end
        bad = 0;
        for (int i = 0; i < pix_q.size(); i++)
            if (pix_q[i] !== base + 32'(4 * i)) bad++;
        checks++;
        if (pix_q.size() != 10 || bad != 0) begin
            errors++;
            $display("FAIL trunc_pixels: n=%0d bad=%0d want 10 in order",
                     pix_q.size(), bad);
        end
        en_b = 1'b0;
        repeat (4) @(negedge clk);
        sel  = 1'b0;
        en_a = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_backpressure();
        int bad = 0;
        logic [31:0] exp;
        pix_ready = 1'b0;
        clear_logs();
        max_cred = 0;
        pulse_start(32'h2000_0000);
        wait_done(0, "bp_fill");
        checks++;
        if (acc_addr.size() != 4 || max_cred != 16) begin
            errors++;
            $display("FAIL bp_fill: bursts=%0d credit=%0d want 4 16",
                     acc_addr.size(), max_cred);
        end
        checks++;
        if (dut_a.fifo_count !== 5'd16 || a_pvalid !== 1'b1 || pix_q.size() != 0) begin
            errors++;
            $display("FAIL bp_full: count=%0d valid=%b popped=%0d want 16 1 0",
                     dut_a.fifo_count, a_pvalid, pix_q.size());
        end
        pulse_start(32'h2000_0100);
        repeat (20) @(negedge clk);
        checks++;
        if (acc_addr.size() != 4 || dut_a.state_q !== REQ) begin
            errors++;
            $display("FAIL bp_stall: bursts=%0d state=%0d want 4 REQ",
                     acc_addr.size(), dut_a.state_q);
        end
        pix_ready = 1'b1;
        wait_done(32, "bp_release");
        checks++;
        if (acc_addr.size() != 8) begin
            errors++;
            $display("FAIL bp_resume: bursts=%0d want 8", acc_addr.size());
        end
        for (int i = 0; i < pix_q.size(); i++) begin
            exp = (i < 16) ? 32'h2000_0000 + 32'(4 * i)
                           : 32'h2000_0100 + 32'(4 * (i - 16));
            if (pix_q[i] !== exp) bad++;
        end
        checks++;
        if (pix_q.size() != 32 || bad != 0) begin
            errors++;
            $display("FAIL bp_pixels: n=%0d bad=%0d want 32 in order",
                     pix_q.size(), bad);
        end
    endtask

    task automatic test_waitrequest();
        int bad = 0;
        int ws0 = wait_seen;
        int sv0 = stab_viol;
        clear_logs();
        wait_on  = n_acc + 1;
        wait_lim = wait_seen + 5;
        pulse_start(32'h3100_0000);
        wait_done(16, "wr");
        checks++;
        if (wait_seen - ws0 != 5 || stab_viol != sv0) begin
            errors++;
            $display("FAIL wr_hold: waits=%0d unstable=%0d want 5 0",
                     wait_seen - ws0, stab_viol - sv0);
        end
        for (int i = 0; i < acc_addr.size(); i++)
            if (acc_addr[i] !== 32'h3100_0000 + 32'(16 * i) || acc_cnt[i] != 4)
                bad++;
        checks++;
        if (acc_addr.size() != 4 || bad != 0) begin
            errors++;
            $display("FAIL wr_bursts: n=%0d bad=%0d want 4 accepted once",
                     acc_addr.size(), bad);
        end
        bad = 0;
        for (int i = 0; i < pix_q.size(); i++)
            if (pix_q[i] !== 32'h3100_0000 + 32'(4 * i)) bad++;
        checks++;
        if (pix_q.size() != 16 || bad != 0) begin
            errors++;
            $display("FAIL wr_pixels: n=%0d bad=%0d want 16 in order",
                     pix_q.size(), bad);
        end
    endtask

    task automatic test_overrun();
        int bad = 0;
        clear_logs();
        pulse_start(32'h4000_0000);
        @(negedge clk);
        pulse_start(32'h4800_0000);
        wait_done(16, "ovr");
        repeat (20) @(negedge clk);
        checks++;
        if (a_ovr !== 1'b1) begin
            errors++;
            $display("FAIL ovr_flag: got %b want 1", a_ovr);
        end
        for (int i = 0; i < pix_q.size(); i++)
            if (pix_q[i] !== 32'h4000_0000 + 32'(4 * i)) bad++;
        checks++;
        if (acc_addr.size() != 4 || pix_q.size() != 16 || bad != 0) begin
            errors++;
            $display("FAIL ovr_frame: bursts=%0d pix=%0d bad=%0d want 4 16 0",
                     acc_addr.size(), pix_q.size(), bad);
        end
        checks++;
        if (dut_a.state_q !== ARMED) begin
            errors++;
            $display("FAIL ovr_state: state=%0d want ARMED", dut_a.state_q);
        end
    endtask

    task automatic test_disable();
        int t = 0;
        clear_logs();
        pulse_start(32'h5000_0000);
        wait_first_burst("dis");
        checks++;
        if (a_udr !== 1'b1 || a_ovr !== 1'b1) begin
            errors++;
            $display("FAIL dis_flags_set: udr=%b ovr=%b want 1 1", a_udr, a_ovr);
        end
        en_a = 1'b0;
        while (a_busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (10) @(negedge clk);
        checks++;
        if (acc_addr.size() != 1 || pix_q.size() != 0 || q_due.size() != 0) begin
            errors++;
            $display("FAIL dis_bursts: bursts=%0d pix=%0d pending=%0d want 1 0 0",
                     acc_addr.size(), pix_q.size(), q_due.size());
        end
        checks++;
        if (a_pvalid !== 1'b0 || dut_a.state_q !== IDLE) begin
            errors++;
            $display("FAIL dis_idle: valid=%b state=%0d want 0 IDLE",
                     a_pvalid, dut_a.state_q);
        end
        checks++;
        if (a_ovr !== 1'b0 || a_udr !== 1'b0) begin
            errors++;
            $display("FAIL dis_flags_clr: ovr=%b udr=%b want 0 0", a_ovr, a_udr);
        end
    endtask

    task automatic test_reset_mid_burst();
        int n;
        en_a = 1'b1;
        repeat (2) @(negedge clk);
        clear_logs();
        pulse_start(32'h6000_0000);
        wait_first_burst("rst");
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (a_read !== 1'b0 || a_addr !== 32'h0 || a_bc !== 9'h0) begin
            errors++;
            $display("FAIL rst_bus: read=%b addr=%h bc=%0d want 0",
                     a_read, a_addr, a_bc);
        end
        checks++;
        if ({a_pvalid, a_busy, a_ovr, a_udr} !== 4'b0 || a_pdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_stat: flags=%b pix=%h want 0",
                     {a_pvalid, a_busy, a_ovr, a_udr}, a_pdata);
        end
        n = acc_addr.size();
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        checks++;
        if (a_pvalid !== 1'b0 || pix_q.size() != 0 || acc_addr.size() != n
            || dut_a.state_q !== ARMED) begin
            errors++;
            $display("FAIL rst_drop: valid=%b pix=%0d bursts=%0d/%0d state=%0d",
                     a_pvalid, pix_q.size(), acc_addr.size(), n, dut_a.state_q);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_truncated();
        test_backpressure();
        test_waitrequest();
        test_overrun();
        test_disable();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_frame_reader.md
Name: video_frame_reader

Overview:
- Avalon-MM burst read master that drives the exported video_dma_s slave of soc_system and fetches a 32bpp frame buffer from HPS DDR.
- Returned words are buffered in an internal FIFO and presented as a valid/ready pixel stream to the downstream HDMI timing/output stage.
- One burst chain is fetched per frame_start pulse, with credit-based flow control so the FIFO can never overflow.

Parameters:
- H_ACTIVE, 640, pixels (32-bit words) per line.
- V_ACTIVE, 480, lines per frame.
- BURST_LEN, 64, words per burst (1..256, must fit the 9-bit burstcount).
- FIFO_DEPTH, 512, pixel FIFO depth in words (power of 2, at least 2*BURST_LEN).

Ports:
- clk  in  1  system clock, the same clock as the video_dma_s interface.
- reset_n  in  1  synchronous active-low reset.
- enable  in  1  level; 0 stops fetching and flushes the block.
- frame_base  in  32  byte address of the frame buffer; sampled on accepted frame_start; must be 4-byte aligned.
- frame_start  in  1  1-cycle pulse from the timing stage requesting the next frame.
- m_address  out  32  byte address to video_dma_s_address.
- m_burstcount  out  9  to video_dma_s_burstcount.
- m_read  out  1  to video_dma_s_read.
- m_write  out  1  tied 0.
- m_writedata  out  32  tied 0.
- m_byteenable  out  4  tied 4'hF.
- m_debugaccess  out  1  tied 0.
- m_waitrequest  in  1  from video_dma_s_waitrequest.
- m_readdata  in  32  from video_dma_s_readdata.
- m_readdatavalid  in  1  from video_dma_s_readdatavalid.
- pix_data  out  32  FIFO head word.
- pix_valid  out  1  FIFO not empty.
- pix_ready  in  1  consumer accept; a pop occurs when pix_valid and pix_ready are both 1.
- busy  out  1  state is not IDLE or ARMED.
- overrun  out  1  sticky; frame_start arrived while a frame was still being fetched.
- underrun  out  1  sticky; pix_ready was high while pix_valid was low during an active frame.

Behaviour:
- Reset: all outputs 0 except m_byteenable=4'hF. FIFO is emptied, all counters are 0, state is IDLE. Reset mid-burst abandons the burst; readdatavalid beats arriving afterwards in IDLE are dropped.
- Frame size: FRAME_WORDS = H_ACTIVE*V_ACTIVE.
- Counters:
  - words_left is 20 bits, words still to be requested.
  - outstanding is 10 bits, words requested but not yet returned.
  - fifo_count is log2(FIFO_DEPTH)+1 bits.
- Burst size: blen = min(BURST_LEN, words_left).
- States:
  - IDLE: moves to ARMED when enable=1.
  - ARMED: on frame_start, latch addr<=frame_base and words_left<=FRAME_WORDS, then go to REQ.
  - REQ: when fifo_count + outstanding + blen <= FIFO_DEPTH, assert m_read=1 with m_address=addr and m_burstcount=blen.
    - Hold all three stable while m_waitrequest=1.
    - On the acceptance cycle (m_read & !m_waitrequest): addr+=blen*4, words_left-=blen, outstanding+=blen.
    - If words_left becomes 0, go to DRAIN.
  - DRAIN: wait for outstanding==0, then go to ARMED.
- Return path:
  - Each readdatavalid pushes m_readdata into the FIFO and decrements outstanding.
  - If the same cycle is a burst acceptance, outstanding changes by blen-1.
  - Push and pop in the same cycle leave fifo_count unchanged.
- Latency and ordering:
  - FIFO is first-word-fall-through: a pushed word is visible on pix_data the next cycle.
  - Bursts are issued back-to-back whenever credit allows, so multiple bursts may be outstanding.
- Overrun: frame_start in REQ or DRAIN sets overrun and is otherwise ignored; the current frame completes.
- Underrun: evaluated in REQ and DRAIN only.
- enable=0 from any state:
  - Stop issuing new bursts; a burst already presented with waitrequest=1 is still held until accepted.
  - Go to DRAIN-flush: wait for outstanding==0, discarding the data.
  - Then empty the FIFO and go to IDLE.
  - overrun and underrun are cleared only on entering IDLE from enable=0, or by reset.
- Address: wraps modulo 2^32 with no error.
- FIFO overflow is structurally impossible; the bench asserts on it.

Decomposition:
- Package video_pkg:
  - AV_DATA_W=32, AV_ADDR_W=32, AV_BURST_W=9.
  - State enum {IDLE, ARMED, REQ, DRAIN, FLUSH}.
  - Function min_blen.
- Sub-module video_pix_fifo: synchronous FWFT FIFO with parameter DEPTH.
  - Ports: clk, reset_n, flush, push, din, pop, dout, empty, count.
  - Also used by the hdmi_sync path.

Test Plan (H_ACTIVE=8, V_ACTIVE=2, BURST_LEN=4, FIFO_DEPTH=16, slave model with 3-cycle read latency):
- Basic frame: enable=1, frame_base=0x3000_0000, one frame_start, pix_ready=1.
  - Exactly 4 bursts of 4, at addresses 0x3000_0000, 0x3000_0010, 0x3000_0020, 0x3000_0030.
  - 16 pixels out in order; returns to ARMED; overrun=0.
- Truncated last burst: H_ACTIVE=5, V_ACTIVE=2.
  - Burstcounts 4, 4, 2; 10 pixels out.
- Backpressure: pix_ready=0 for the whole frame.
  - Issuing stops at fifo_count+outstanding=16.
  - Releasing pix_ready resumes fetching; 16 words delivered, none lost.
- Waitrequest: slave holds waitrequest=1 for 5 cycles on burst 2.
  - m_address and m_burstcount stay stable and the burst is accepted exactly once.
- Overrun: second frame_start during REQ.
  - overrun=1; exactly 16 words fetched for the first frame; no second frame starts.
- Disable mid-frame: enable=0 with 4 words outstanding.
  - No new m_read; the 4 returning words are discarded.
  - FIFO empties, pix_valid=0, state IDLE, flags cleared.
  - Reset mid-burst: all outputs at reset values the next cycle.
